// File: rtl/load_store_unit_if.sv
// Request, data-memory bus and writeback signals of the load/store unit.
// The slave modport is the unit itself. The master modport is the side that
// drives requests and answers the memory bus.
interface load_store_unit_if #(
    parameter int XLEN      = 32,
    parameter int REG_SEL_W = 5
);
    logic                   iRead;
    logic                   iWrite;
    logic [XLEN-1:0]        iAddr;
    logic [XLEN-1:0]        iData;
    logic [2:0]             iOpType;
    logic [REG_SEL_W-1:0]   iRdAddr;
    logic                   iFlush;
    logic                   oReady;

    logic                   oMemReq;
    logic                   oMemWe;
    logic [XLEN-1:0]        oMemAddr;
    logic [XLEN-1:0]        oMemWdata;
    logic [XLEN/8-1:0]      oMemBe;
    logic                   iMemAck;
    logic [XLEN-1:0]        iMemRdata;

    logic                   oRegDv;
    logic [REG_SEL_W-1:0]   oRegAddr;
    logic [XLEN-1:0]        oRegData;
    logic                   oErr;
    logic [1:0]             oErrCause;

    modport slave (
        input  iRead, iWrite, iAddr, iData, iOpType, iRdAddr, iFlush,
        output oReady,
        output oMemReq, oMemWe, oMemAddr, oMemWdata, oMemBe,
        input  iMemAck, iMemRdata,
        output oRegDv, oRegAddr, oRegData, oErr, oErrCause
    );

    modport master (
        output iRead, iWrite, iAddr, iData, iOpType, iRdAddr, iFlush,
        input  oReady,
        input  oMemReq, oMemWe, oMemAddr, oMemWdata, oMemBe,
        output iMemAck, iMemRdata,
        input  oRegDv, oRegAddr, oRegData, oErr, oErrCause
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: checks an ALU memory op, runs one req/ack bus
// transaction at a time, and turns load data into a writeback record.
// Catches misaligned accesses, illegal op types and a bus that never answers.
module load_store_unit #(
    parameter int XLEN        = 32,
    parameter int REG_SEL_W   = 5,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             iClk,
    input  logic             iRst,
    load_store_unit_if.slave bus
);
    localparam int NB     = XLEN / 8;
    localparam int LANE_W = $clog2(NB);
    localparam int CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int TO_LAST_I = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t                 state;
    logic [CNT_W-1:0]       timeoutCnt;
    logic                   killFlag;
    logic                   isLoad;
    logic [LANE_W-1:0]      lane;
    logic [2:0]             opType;
    logic [REG_SEL_W-1:0]   rdAddr;

    logic [LANE_W-1:0]      inLane;
    logic [1:0]             inSize;
    logic                   opIllegal;
    logic                   opMisaligned;
    logic [NB-1:0]          inBe;
    logic [XLEN-1:0]        inWdata;
    logic [XLEN-1:0]        inAlignedAddr;

    // Byte-enable pattern for an access size before it is moved to its lane.
    function automatic logic [NB-1:0] beMask(input logic [1:0] size);
        case (size)
            2'b00:   return NB'(1);
            2'b01:   return NB'(3);
            2'b10:   return NB'(15);
            default: return '1;
        endcase
    endfunction

    // Bring the addressed bytes down to bit 0, then sign- or zero-extend.
    function automatic logic [XLEN-1:0] extendLoad(input logic [XLEN-1:0]   raw,
                                                   input logic [LANE_W-1:0] ln,
                                                   input logic [2:0]        op);
        logic [XLEN-1:0] s;
        s = raw >> {ln, 3'b000};
        case (op)
            3'b000:  return XLEN'($signed(s[7:0]));
            3'b001:  return XLEN'($signed(s[15:0]));
            3'b010:  return XLEN'($signed(s[31:0]));
            3'b100:  return XLEN'(s[7:0]);
            3'b101:  return XLEN'(s[15:0]);
            3'b110:  return XLEN'(s[31:0]);
            default: return s;
        endcase
    endfunction

    // Decode the presented op: legality, alignment, lane placement.
    always_comb begin
        inLane        = bus.iAddr[LANE_W-1:0];
        inSize        = bus.iOpType[1:0];
        opIllegal     = (bus.iRead & bus.iWrite)
                      | (bus.iOpType == 3'b111)
                      | (bus.iWrite & bus.iOpType[2])
                      | ((XLEN == 32) & ((bus.iOpType == 3'b011) | (bus.iOpType == 3'b110)));
        case (inSize)
            2'b00:   opMisaligned = 1'b0;
            2'b01:   opMisaligned = bus.iAddr[0];
            2'b10:   opMisaligned = |bus.iAddr[1:0];
            default: opMisaligned = |bus.iAddr[2:0];
        endcase
        inBe          = beMask(inSize) << inLane;
        inWdata       = bus.iData << {inLane, 3'b000};
        inAlignedAddr = {bus.iAddr[XLEN-1:LANE_W], {LANE_W{1'b0}}};
    end

    // IDLE/BUS/RESP sequencer; every output is registered here.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state         <= IDLE;
            timeoutCnt    <= '0;
            killFlag      <= 1'b0;
            bus.oReady    <= 1'b1;
            bus.oMemReq   <= 1'b0;
            bus.oMemWe    <= 1'b0;
            bus.oMemAddr  <= '0;
            bus.oMemWdata <= '0;
            bus.oMemBe    <= '0;
            bus.oRegDv    <= 1'b0;
            bus.oRegAddr  <= '0;
            bus.oRegData  <= '0;
            bus.oErr      <= 1'b0;
            bus.oErrCause <= 2'b00;
        end else begin
            bus.oRegDv <= 1'b0;
            bus.oErr   <= 1'b0;
            case (state)
                IDLE: begin
                    if ((bus.iRead | bus.iWrite) & ~bus.iFlush) begin
                        if (opIllegal) begin
                            bus.oErr      <= 1'b1;
                            bus.oErrCause <= 2'b10;
                        end else if (opMisaligned) begin
                            bus.oErr      <= 1'b1;
                            bus.oErrCause <= 2'b01;
                        end else begin
                            state         <= BUS;
                            bus.oReady    <= 1'b0;
                            bus.oMemReq   <= 1'b1;
                            bus.oMemWe    <= bus.iWrite;
                            bus.oMemAddr  <= inAlignedAddr;
                            bus.oMemWdata <= inWdata;
                            bus.oMemBe    <= inBe;
                            isLoad        <= bus.iRead;
                            lane          <= inLane;
                            opType        <= bus.iOpType;
                            rdAddr        <= bus.iRdAddr;
                            timeoutCnt    <= '0;
                            killFlag      <= 1'b0;
                        end
                    end
                end
                BUS: begin
                    if (bus.iMemAck) begin
                        // A flush arriving with the ack still cancels the writeback.
                        bus.oMemReq <= 1'b0;
                        killFlag    <= 1'b0;
                        timeoutCnt  <= '0;
                        if (isLoad) begin
                            state        <= RESP;
                            bus.oRegDv   <= ~killFlag & ~bus.iFlush & (rdAddr != '0);
                            bus.oRegAddr <= rdAddr;
                            bus.oRegData <= extendLoad(bus.iMemRdata, lane, opType);
                        end else begin
                            state      <= IDLE;
                            bus.oReady <= 1'b1;
                        end
                    end else begin
                        if (bus.iFlush) begin
                            killFlag <= 1'b1;
                        end
                        if ((TIMEOUT_CYC != 0) && (timeoutCnt == TO_LAST)) begin
                            state         <= IDLE;
                            bus.oReady    <= 1'b1;
                            bus.oMemReq   <= 1'b0;
                            bus.oErr      <= 1'b1;
                            bus.oErrCause <= 2'b11;
                            timeoutCnt    <= '0;
                            killFlag      <= 1'b0;
                        end else begin
                            timeoutCnt <= timeoutCnt + CNT_W'(1);
                        end
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    bus.oReady <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    bus.oReady <= 1'b1;
                end
            endcase
        end
    end
endmodule
